ir_gate_controller: RTL

//  Sequencer for the infrared people counter. Two IR beams (A outside, B inside) sit across a doorway.
//  The block synchronises and debounces both beams and decodes walk direction with a state machine.

---
 rtl/ir_gate_if.sv | 25 ++
 rtl/ir_gate_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_gate_if.sv
// Bus bundle for the IR gate controller: raw beams and clear toward the block,
// counter events and occupancy status back out.
interface ir_gate_if #(
   parameter int unsigned CNT_W = 10
);
   logic             beam_a_raw;
   logic             beam_b_raw;
   logic             clr;
   logic             inc_o;
   logic             dec_o;
   logic [CNT_W-1:0] occupancy;
   logic             empty;
   logic             full;
   logic             fault;

   modport master (
      output beam_a_raw, beam_b_raw, clr,
      input  inc_o, dec_o, occupancy, empty, full, fault
   );

   modport slave (
      input  beam_a_raw, beam_b_raw, clr,
      output inc_o, dec_o, occupancy, empty, full, fault
   );
endinterface

// File: rtl/ir_gate_controller.sv
// IR doorway people-counter sequencer: synchronises and debounces two beams,
// decodes walk direction, emits entry/exit pulses and keeps a local occupancy.
// Optional feature macro: IR_GATE_CAPACITY_EN (saturating occupancy with full flag).
module ir_gate_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned TIMEOUT_CYCLES  = 500000,
   parameter int unsigned CNT_W           = 10,
   parameter int unsigned MAX_OCC         = 1000
) (
   input  logic     clk,
   input  logic     rst_n,
   ir_gate_if.slave bus
);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TM_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IN_A     = 3'd1,
      IN_AB    = 3'd2,
      IN_B     = 3'd3,
      OUT_B    = 3'd4,
      OUT_BA   = 3'd5,
      OUT_A    = 3'd6,
      WAIT_CLR = 3'd7
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       sync1;      // bit 1 = beam A, bit 0 = beam B
   logic [1:0]       sync2;
   logic [1:0]       filt;
   logic [DB_W-1:0]  db_cnt [2];
   logic [TM_W-1:0]  tmo_cnt;
   logic             tmo_hit_c;
   logic             entry_c;
   logic             exit_c;
   logic             fsm_fault_c;
   logic             entry_q;
   logic             exit_q;
   logic [CNT_W-1:0] occ_q;
   logic [CNT_W-1:0] occ_nxt_c;
   logic             inc_c;
   logic             dec_c;
   logic             rej_c;
   logic             empty_c;
   logic             full_c;
   logic             inc_q;
   logic             dec_q;
   logic             fault_q;

   // Capacity limit must be representable in the occupancy register
   if (64'(MAX_OCC) >= (64'd1 << CNT_W)) begin : g_max_occ_check
      $error("MAX_OCC must be below 2**CNT_W");
   end

   // Two-flop synchronisers followed by one debounce counter per beam
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= {bus.beam_a_raw, bus.beam_b_raw};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Dwell timer: counts clocks spent in one passage state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state_nxt != state || state == IDLE || state == WAIT_CLR) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit_c = (state != IDLE) && (state != WAIT_CLR) &&
                      (tmo_cnt == TM_W'(TIMEOUT_CYCLES - 1));

   // Next state from filtered {a,b}; a two-bit jump lands in WAIT_CLR
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: case (filt)
            2'b10:   state_nxt = IN_A;
            2'b01:   state_nxt = OUT_B;
            2'b11:   state_nxt = WAIT_CLR;
            default: state_nxt = IDLE;
         endcase
         IN_A: case (filt)
            2'b11:   state_nxt = IN_AB;
            2'b00:   state_nxt = IDLE;
            2'b10:   state_nxt = IN_A;
            default: state_nxt = WAIT_CLR;
         endcase
         IN_AB: case (filt)
            2'b01:   state_nxt = IN_B;
            2'b10:   state_nxt = IN_A;
            2'b11:   state_nxt = IN_AB;
            default: state_nxt = WAIT_CLR;
         endcase
         IN_B: case (filt)
            2'b00:   state_nxt = IDLE;
            2'b11:   state_nxt = IN_AB;
            2'b01:   state_nxt = IN_B;
            default: state_nxt = WAIT_CLR;
         endcase
         OUT_B: case (filt)
            2'b11:   state_nxt = OUT_BA;
            2'b00:   state_nxt = IDLE;
            2'b01:   state_nxt = OUT_B;
            default: state_nxt = WAIT_CLR;
         endcase
         OUT_BA: case (filt)
            2'b10:   state_nxt = OUT_A;
            2'b01:   state_nxt = OUT_B;
            2'b11:   state_nxt = OUT_BA;
            default: state_nxt = WAIT_CLR;
         endcase
         OUT_A: case (filt)
            2'b00:   state_nxt = IDLE;
            2'b11:   state_nxt = OUT_BA;
            2'b10:   state_nxt = OUT_A;
            default: state_nxt = WAIT_CLR;
         endcase
         WAIT_CLR: begin
            if (filt == 2'b00) state_nxt = IDLE;
         end
      endcase
      // A legal move resets the dwell timer, so timeout only applies when stuck
      if (tmo_hit_c && state_nxt == state) state_nxt = WAIT_CLR;
   end

   // FSM decoded events: completed entry/exit and illegal/timeout abort
   always_comb begin
      entry_c     = 1'b0;
      exit_c      = 1'b0;
      fsm_fault_c = 1'b0;
      if (state == IN_B  && state_nxt == IDLE) entry_c = 1'b1;
      if (state == OUT_A && state_nxt == IDLE) exit_c  = 1'b1;
      if (state != WAIT_CLR && state_nxt == WAIT_CLR) fsm_fault_c = 1'b1;
   end

   // Occupancy update, capacity qualification and clear priority
   always_comb begin
      empty_c = (occ_q == '0);
`ifdef IR_GATE_CAPACITY_EN
      full_c  = (occ_q == CNT_W'(MAX_OCC));
      rej_c   = (entry_q && full_c) || (exit_q && empty_c);
`else
      full_c  = 1'b0;
      rej_c   = 1'b0;
`endif
      inc_c     = entry_q && !rej_c;
      dec_c     = exit_q && !rej_c;
      occ_nxt_c = occ_q;
      if (inc_c) occ_nxt_c = occ_q + 1'b1;
      if (dec_c) occ_nxt_c = occ_q - 1'b1;
      if (bus.clr) occ_nxt_c = '0;
   end

   // Event pipeline and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= 1'b0;
         exit_q  <= 1'b0;
         occ_q   <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         entry_q <= entry_c;
         exit_q  <= exit_c;
         occ_q   <= occ_nxt_c;
         inc_q   <= inc_c;
         dec_q   <= dec_c;
         fault_q <= fsm_fault_c | rej_c;
      end
   end

   assign bus.inc_o     = inc_q;
   assign bus.dec_o     = dec_q;
   assign bus.fault     = fault_q;
   assign bus.occupancy = occ_q;
   assign bus.empty     = empty_c;
   assign bus.full      = full_c;

endmodule
